// File: rtl/ntt_beat_buffer.sv
// ntt_beat_buffer
//   Ping-pong beat buffer for the NTT load/store path. One polynomial of DEPTH
//   beats (LANES x COEF_W bits each) is captured into one of two banks. Each
//   bank is then replayed in the beat order that was latched when its first
//   beat arrived: natural, bit-reversed, or low/high deinterleave. While one
//   bank drains, the other bank fills.
//
// Ports
//   clk, rstn        clock; asynchronous reset, active when rstn=1
//   cfg_vld/order    strobe that loads the pending replay order (3 = natural)
//   ld_vld/rdy/dat   input beat stream, lane 0 in the LSBs
//   sw_vld/rdy/dat   output beat stream
//   sw_lst           marks the final beat of a bank
//   bank_full        per-bank full flags, bit b = bank b
module ntt_beat_buffer #(
  parameter int LANES  = 8,
  parameter int COEF_W = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_vld,
  input  logic [1:0]              cfg_order,
  input  logic                    ld_vld,
  output logic                    ld_rdy,
  input  logic [LANES*COEF_W-1:0] ld_dat,
  output logic                    sw_vld,
  input  logic                    sw_rdy,
  output logic [LANES*COEF_W-1:0] sw_dat,
  output logic                    sw_lst,
  output logic [1:0]              bank_full
);

  localparam int DATA_W = LANES * COEF_W;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(DEPTH - 1);

  function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = k[ADDR_W-1-i];
    return r;
  endfunction

  // Replay beat k -> storage address within the bank.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] k,
                                                 input logic [1:0]        ord);
    logic [ADDR_W-1:0] a;
    case (ord)
      2'd1:    a = bit_rev(k);
      2'd2:    a = {k[ADDR_W-2:0], k[ADDR_W-1]};
      default: a = k;
    endcase
    return a;
  endfunction

  logic [DATA_W-1:0] mem [2*DEPTH];

  // Write side state
  logic              wbank_q, wbank_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0][1:0]   order_q, order_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              ld_rdy_q, ld_rdy_d;
  // Read issue side: ibank/icnt walk ahead of the output stage so the next
  // bank can be prefetched before the current one has fully handshaken.
  logic              ibank_q, ibank_d;
  logic [ADDR_W-1:0] icnt_q, icnt_d;
  logic              rbank_q, rbank_d;
  // Two-entry output stage: head drives the ports, skid absorbs the beat
  // already read from memory when the consumer stalls.
  logic              hd_vld_q, hd_vld_d;
  logic              hd_lst_q, hd_lst_d;
  logic [DATA_W-1:0] hd_dat_q, hd_dat_d;
  logic              sk_vld_q, sk_vld_d;
  logic              sk_lst_q, sk_lst_d;
  logic [DATA_W-1:0] sk_dat_q, sk_dat_d;

  logic              ld_acc, pop, issue, rd_lst;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dat;

  assign ld_acc  = ld_vld && ld_rdy_q;
  assign pop     = hd_vld_q && sw_rdy;
  // A read may be issued when a slot is free after this cycle's pop.
  assign issue   = bank_full_q[ibank_q] && (!sk_vld_q || pop);
  assign rd_addr = map_addr(icnt_q, order_q[ibank_q]);
  assign rd_dat  = mem[{ibank_q, rd_addr}];
  assign rd_lst  = (icnt_q == LAST_BEAT);

  always_comb begin
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    pend_d      = pend_q;
    order_d     = order_q;
    bank_full_d = bank_full_q;
    ibank_d     = ibank_q;
    icnt_d      = icnt_q;
    rbank_d     = rbank_q;
    hd_vld_d    = hd_vld_q;
    hd_lst_d    = hd_lst_q;
    hd_dat_d    = hd_dat_q;
    sk_vld_d    = sk_vld_q;
    sk_lst_d    = sk_lst_q;
    sk_dat_d    = sk_dat_q;

    if (cfg_vld) pend_d = cfg_order;

    if (ld_acc) begin
      // Order is captured with the first beat; a same-cycle strobe wins.
      if (wcnt_q == '0) order_d[wbank_q] = cfg_vld ? cfg_order : pend_q;
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST_BEAT) begin
        bank_full_d[wbank_q] = 1'b1;
        wbank_d              = ~wbank_q;
        wcnt_d               = '0;
      end
    end

    if (pop) begin
      if (sk_vld_q) begin
        hd_dat_d = sk_dat_q;
        hd_lst_d = sk_lst_q;
        sk_vld_d = 1'b0;
      end else begin
        hd_vld_d = 1'b0;
      end
      if (hd_lst_q) begin
        bank_full_d[rbank_q] = 1'b0;
        rbank_d              = ~rbank_q;
      end
    end

    if (issue) begin
      icnt_d = icnt_q + 1'b1;
      if (rd_lst) begin
        ibank_d = ~ibank_q;
        icnt_d  = '0;
      end
      if (!hd_vld_d) begin
        hd_vld_d = 1'b1;
        hd_dat_d = rd_dat;
        hd_lst_d = rd_lst;
      end else begin
        sk_vld_d = 1'b1;
        sk_dat_d = rd_dat;
        sk_lst_d = rd_lst;
      end
    end

    ld_rdy_d = !bank_full_d[wbank_d];
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      pend_q      <= 2'd0;
      order_q     <= '0;
      bank_full_q <= 2'b00;
      ld_rdy_q    <= 1'b0;
      ibank_q     <= 1'b0;
      icnt_q      <= '0;
      rbank_q     <= 1'b0;
      hd_vld_q    <= 1'b0;
      hd_lst_q    <= 1'b0;
      hd_dat_q    <= '0;
      sk_vld_q    <= 1'b0;
      sk_lst_q    <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      order_q     <= order_d;
      bank_full_q <= bank_full_d;
      ld_rdy_q    <= ld_rdy_d;
      ibank_q     <= ibank_d;
      icnt_q      <= icnt_d;
      rbank_q     <= rbank_d;
      hd_vld_q    <= hd_vld_d;
      hd_lst_q    <= hd_lst_d;
      hd_dat_q    <= hd_dat_d;
      sk_vld_q    <= sk_vld_d;
      sk_lst_q    <= sk_lst_d;
    end
  end

  always_ff @(posedge clk) begin
    sk_dat_q <= sk_dat_d;
    if (ld_acc) mem[{wbank_q, wcnt_q}] <= ld_dat;
  end

  assign ld_rdy    = ld_rdy_q;
  assign sw_vld    = hd_vld_q;
  assign sw_dat    = hd_dat_q;
  assign sw_lst    = hd_lst_q;
  assign bank_full = bank_full_q;

endmodule

// File: tb/tb_ntt_beat_buffer.sv
module tb_ntt_beat_buffer;
  localparam int LANES  = 8;
  localparam int COEF_W = 16;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DW     = LANES * COEF_W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_vld = 1'b0;
  logic [1:0]    cfg_order = 2'd0;
  logic          ld_vld = 1'b0;
  logic          ld_rdy;
  logic [DW-1:0] ld_dat = '0;
  logic          sw_vld;
  logic          sw_rdy = 1'b0;
  logic [DW-1:0] sw_dat;
  logic          sw_lst;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  ntt_beat_buffer #(.LANES(LANES), .COEF_W(COEF_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .cfg_vld(cfg_vld), .cfg_order(cfg_order),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_dat(ld_dat),
    .sw_vld(sw_vld), .sw_rdy(sw_rdy), .sw_dat(sw_dat), .sw_lst(sw_lst),
    .bank_full(bank_full)
  );

  typedef struct { logic [DW-1:0] dat; logic lst; } exp_t;
  typedef struct { int scn; int k; logic [DW-1:0] dat; logic lst; } vec_t;

  int total = 0;
  int bad = 0;
  exp_t sbq[$];
  vec_t tbl[$];
  logic [DW-1:0] cap_dat[$];
  logic          cap_lst[$];

  // Reference model state (write side) and stall tracking
  logic [DW-1:0] mbank [2][DEPTH];
  int            m_wbank, m_wcnt, n_acc;
  logic [1:0]    m_pend;
  logic [1:0]    m_ord [2];
  logic          prev_stall;
  logic [DW-1:0] prev_dat;
  logic          prev_lst;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic bound_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, actual=timeout required=event", nm);
  endtask

  function automatic logic [DW-1:0] mkb(input int base, input int step);
    logic [DW-1:0] b;
    for (int j = 0; j < LANES; j++) b[j*COEF_W +: COEF_W] = COEF_W'(base + j*step);
    return b;
  endfunction

  function automatic int tb_map(input int k, input logic [1:0] ord);
    int r;
    if (ord == 2'd1) begin
      r = 0;
      for (int b = 0; b < ADDR_W; b++) r = (r << 1) | ((k >> b) & 1);
    end else if (ord == 2'd2) begin
      r = (k < DEPTH/2) ? 2*k : 2*(k - DEPTH/2) + 1;
    end else begin
      r = k;
    end
    return r;
  endfunction

  // Model + scoreboard: sampled on the falling edge, decisions apply at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      sbq.delete();
      m_wbank = 0; m_wcnt = 0; n_acc = 0; m_pend = 2'd0;
      m_ord[0] = 2'd0; m_ord[1] = 2'd0;
      prev_stall = 1'b0;
    end else begin
      if (sw_vld) begin
        if (prev_stall) begin
          chk("hold_dat", sw_dat, prev_dat);
          chk("hold_lst", DW'(sw_lst), DW'(prev_lst));
        end
        if (sw_rdy) begin
          if (sbq.size() == 0) begin
            chk("extra_beat", DW'(1), DW'(0));
          end else begin
            e = sbq.pop_front();
            chk("sb_dat", sw_dat, e.dat);
            chk("sb_lst", DW'(sw_lst), DW'(e.lst));
          end
          cap_dat.push_back(sw_dat);
          cap_lst.push_back(sw_lst);
        end
        prev_stall = !sw_rdy;
        prev_dat   = sw_dat;
        prev_lst   = sw_lst;
      end else begin
        prev_stall = 1'b0;
      end
      if (ld_vld && ld_rdy) begin
        if (m_wcnt == 0) m_ord[m_wbank] = cfg_vld ? cfg_order : m_pend;
        mbank[m_wbank][m_wcnt] = ld_dat;
        n_acc++;
        if (m_wcnt == DEPTH-1) begin
          for (int k = 0; k < DEPTH; k++) begin
            e.dat = mbank[m_wbank][tb_map(k, m_ord[m_wbank])];
            e.lst = (k == DEPTH-1);
            sbq.push_back(e);
          end
          m_wbank ^= 1;
          m_wcnt = 0;
        end else begin
          m_wcnt++;
        end
      end
      if (cfg_vld) m_pend = cfg_order;
    end
  end

  function automatic logic [DW-1:0] pat_beat(input int pat, input int off, input int i);
    if (pat == 1) return (i % 2 == 0) ? mkb((i/2)*8, 1) : mkb(512 + (i/2)*8, 1);
    if (pat == 2) return mkb(i, 0);
    return mkb(off + i*8, 1);
  endfunction

  // Drives n beats; called at posedge+1. cfg strobe pulses with beat cfg_at.
  task automatic load(input int n, input int gap, input int pat, input int off,
                      input int cfg_at, input logic [1:0] cfg_val);
    int g;
    for (int i = 0; i < n; i++) begin
      ld_vld = 1'b1;
      ld_dat = pat_beat(pat, off, i);
      if (i == cfg_at) begin cfg_vld = 1'b1; cfg_order = cfg_val; end
      g = 0;
      while (!ld_rdy && g < 1000) begin @(posedge clk); #1; cfg_vld = 1'b0; g++; end
      if (g >= 1000) begin bound_fail("load_rdy"); ld_vld = 1'b0; return; end
      @(posedge clk); #1;
      cfg_vld = 1'b0;
      ld_vld  = 1'b0;
      repeat (gap - 1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic cfg_pulse(input logic [1:0] v);
    cfg_vld = 1'b1; cfg_order = v;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget);
    int g = 0;
    while (cap_dat.size() < target && g < budget) begin @(posedge clk); #1; g++; end
    if (cap_dat.size() < target) bound_fail("wait_out");
  endtask

  task automatic check_table(input int scn, input int base);
    foreach (tbl[i]) begin
      if (tbl[i].scn == scn) begin
        if (base + tbl[i].k < cap_dat.size()) begin
          chk($sformatf("tbl%0d_k%0d_dat", scn, tbl[i].k), cap_dat[base + tbl[i].k], tbl[i].dat);
          chk($sformatf("tbl%0d_k%0d_lst", scn, tbl[i].k), DW'(cap_lst[base + tbl[i].k]), DW'(tbl[i].lst));
        end else begin
          bound_fail($sformatf("tbl%0d_k%0d_missing", scn, tbl[i].k));
        end
      end
    end
  endtask

  task automatic add_vec(input int scn, input int k, input logic [DW-1:0] d, input logic l);
    vec_t v;
    v.scn = scn; v.k = k; v.dat = d; v.lst = l;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lst_n, seen, acc0;
    // scn, output index k, required beat, required sw_lst
    add_vec(1, 0,   mkb(0, 1), 1'b0);
    add_vec(1, 64,  mkb(512, 1), 1'b0);
    add_vec(1, 127, mkb(1016, 1), 1'b1);
    add_vec(2, 0,   mkb(0, 1), 1'b0);
    add_vec(2, 63,  mkb(504, 1), 1'b0);
    add_vec(2, 64,  mkb(512, 1), 1'b0);
    add_vec(2, 127, mkb(1016, 1), 1'b1);
    add_vec(3, 1,   mkb(64, 0), 1'b0);
    add_vec(3, 2,   mkb(32, 0), 1'b0);
    add_vec(3, 3,   mkb(96, 0), 1'b0);
    add_vec(3, 127, mkb(127, 0), 1'b1);
    add_vec(4, 1,   mkb(8, 1), 1'b0);
    add_vec(4, 127, mkb(1016, 1), 1'b1);
    add_vec(4, 128, mkb(1024, 1), 1'b0);
    add_vec(4, 129, mkb(1024 + 512, 1), 1'b0);
    add_vec(4, 255, mkb(1024 + 1016, 1), 1'b1);
    add_vec(5, 0,   mkb(2048, 1), 1'b0);
    add_vec(5, 127, mkb(2048 + 1016, 1), 1'b1);

    // Reset state
    #2 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_rdy", DW'(ld_rdy), DW'(0));
    chk("rst_sw_vld", DW'(sw_vld), DW'(0));
    chk("rst_sw_lst", DW'(sw_lst), DW'(0));
    chk("rst_sw_dat", sw_dat, '0);
    chk("rst_bank_full", DW'(bank_full), DW'(0));
    rstn = 1'b0;
    @(posedge clk); #1;

    // Natural order, continuous load, sw_rdy high
    sw_rdy = 1'b1;
    base = cap_dat.size();
    load(DEPTH, 1, 0, 0, -1, 2'd0);
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (sw_vld) seen = 1; end
    chk("nat_latency", DW'(seen), DW'(1));
    wait_out(base + DEPTH, 1000);
    check_table(1, base);
    lst_n = 0;
    for (int k = base; k < cap_lst.size(); k++) lst_n += int'(cap_lst[k]);
    chk("nat_lst_count", DW'(lst_n), DW'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("nat_drained_full", DW'(bank_full), DW'(0));

    // Deinterleave, one beat every 8 cycles
    cfg_pulse(2'd2);
    base = cap_dat.size();
    load(DEPTH, 8, 1, 0, -1, 2'd0);
    wait_out(base + DEPTH, 1000);
    check_table(2, base);

    // Bit-reversed
    cfg_pulse(2'd1);
    base = cap_dat.size();
    load(DEPTH, 1, 2, 0, -1, 2'd0);
    wait_out(base + DEPTH, 1000);
    check_table(3, base);

    // Backpressure: sink off for 300 cycles, then random 30% ready
    cfg_pulse(2'd0);
    sw_rdy = 1'b0;
    base = cap_dat.size();
    acc0 = n_acc;
    fork
      begin
        int k = 0, g = 0;
        logic r;
        while (k < 4*DEPTH && g < 8000) begin
          ld_vld = 1'b1;
          ld_dat = mkb(k*8, 1);
          r = ld_rdy;
          @(posedge clk); #1;
          if (r) k++;
          g++;
        end
        ld_vld = 1'b0;
        if (k < 4*DEPTH) bound_fail("bp_load");
      end
      begin
        int g = 0;
        repeat (300) @(posedge clk);
        #1;
        chk("bp_accepted", DW'(n_acc - acc0), DW'(2*DEPTH));
        chk("bp_ld_rdy", DW'(ld_rdy), DW'(0));
        chk("bp_both_full", DW'(bank_full), DW'(3));
        while (cap_dat.size() < base + 4*DEPTH && g < 8000) begin
          sw_rdy = ($urandom_range(0, 9) < 3);
          @(posedge clk); #1;
          g++;
        end
        sw_rdy = 1'b1;
        if (cap_dat.size() < base + 4*DEPTH) bound_fail("bp_drain");
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("bp_out_count", DW'(cap_dat.size() - base), DW'(4*DEPTH));
    chk("bp_sb_empty", DW'(sbq.size()), DW'(0));

    // Per-bank order: bank 0 natural, strobe to bit-reversed at wcnt=40
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    cfg_pulse(2'd0);
    sw_rdy = 1'b1;
    base = cap_dat.size();
    load(DEPTH, 1, 0, 0, 40, 2'd1);
    load(DEPTH, 1, 0, 1024, -1, 2'd0);
    wait_out(base + 2*DEPTH, 1000);
    check_table(4, base);

    // Reset mid-fill with bank 1 full
    sw_rdy = 1'b0;
    load(DEPTH, 1, 0, 0, -1, 2'd0);
    load(DEPTH, 1, 0, 1024, -1, 2'd0);
    base = cap_dat.size();
    begin
      int g = 0;
      while (cap_dat.size() < base + DEPTH && g < 1000) begin sw_rdy = 1'b1; @(posedge clk); #1; g++; end
      sw_rdy = 1'b0;
      if (cap_dat.size() < base + DEPTH) bound_fail("mid_drain0");
    end
    load(40, 1, 0, 3000, -1, 2'd0);
    chk("mid_full_before", DW'(bank_full), DW'(2));
    rstn = 1'b1;
    #1;
    chk("mid_rst_ld_rdy", DW'(ld_rdy), DW'(0));
    chk("mid_rst_sw_vld", DW'(sw_vld), DW'(0));
    chk("mid_rst_sw_lst", DW'(sw_lst), DW'(0));
    chk("mid_rst_sw_dat", sw_dat, '0);
    chk("mid_rst_full", DW'(bank_full), DW'(0));
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    sw_rdy = 1'b1;
    base = cap_dat.size();
    load(DEPTH, 1, 0, 2048, -1, 2'd0);
    wait_out(base + DEPTH, 1000);
    repeat (20) @(posedge clk);
    #1;
    check_table(5, base);
    chk("mid_out_count", DW'(cap_dat.size() - base), DW'(DEPTH));
    chk("mid_sb_empty", DW'(sbq.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
